// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A host-side controller.
// Holds the controller state encoding, bus-timer types and command-byte constants.
package pic_pkg;

    typedef enum logic [3:0] {
        StIdle, StWIcw1, StWIcw2, StWIcw4, StWOcw1, StWOcw3,
        StReady, StAck1, StAckGap, StAck2, StVecHold, StEoiWr
    } pic_state_e;

    typedef enum logic [1:0] {OpWrite, OpPulse, OpGap} bus_op_e;

    typedef enum logic [2:0] {PhIdle, PhSetup, PhStrobe, PhHold, PhGap} bus_phase_e;

    localparam logic A0Icw1 = 1'b0;
    localparam logic A0Icw2 = 1'b1;
    localparam logic A0Icw4 = 1'b1;
    localparam logic A0Ocw1 = 1'b1;
    localparam logic A0Ocw3 = 1'b0;
    localparam logic A0Eoi  = 1'b0;

    localparam logic [2:0] EoiSpecificPrefix = 3'b011;
    localparam logic [7:0] EoiNonSpecific    = 8'h20;

    localparam int unsigned Icw1Ic4Bit  = 0;
    localparam int unsigned Icw4AeoiBit = 1;

    function automatic logic [7:0] specific_eoi(input logic [2:0] level);
        return {EoiSpecificPrefix, 2'b00, level};
    endfunction

endpackage

// File: rtl/pic_host_ctrl_bus_cycle.sv
// Bus timer: setup/strobe/hold/gap sequence for PIC writes, bare INTA low phases
// and bare gap intervals. Strobes are decoded combinationally so abort/reset act at once.
module pic_bus_cycle
    import pic_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    start,
    input  logic    abort,
    input  bus_op_e op,
    output logic    idle,
    output logic    done,
    output logic    last_strobe,
    output logic    bus_drive,
    output logic    we_n,
    output logic    inta_n
);

    localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GapLast    = 4'(GAP_CYCLES - 1);

    bus_phase_e phase_q, phase_d;
    bus_op_e    op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       strobe_on;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PhIdle;
            op_q    <= OpWrite;
            cnt_q   <= 4'd0;
        end else begin
            phase_q <= phase_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (phase_q)
            PhIdle: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = 4'd0;
                    case (op)
                        OpWrite: phase_d = PhSetup;
                        OpPulse: phase_d = PhStrobe;
                        default: phase_d = PhGap;
                    endcase
                end
            end
            PhSetup: begin
                phase_d = PhStrobe;
                cnt_d   = 4'd0;
            end
            PhStrobe: begin
                if (cnt_q == StrobeLast) begin
                    if (op_q == OpWrite) begin
                        phase_d = PhHold;
                    end else begin
                        phase_d = PhIdle;
                        done    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PhHold: begin
                phase_d = PhGap;
                cnt_d   = 4'd0;
            end
            PhGap: begin
                if (cnt_q == GapLast) begin
                    phase_d = PhIdle;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: phase_d = PhIdle;
        endcase
        if (abort) begin
            phase_d = PhIdle;
            done    = 1'b0;
        end
    end

    assign idle        = (phase_q == PhIdle);
    assign last_strobe = (phase_q == PhStrobe) && (cnt_q == StrobeLast);
    assign strobe_on   = (phase_q == PhStrobe) && !abort;
    assign we_n        = !(strobe_on && op_q == OpWrite);
    assign inta_n      = !(strobe_on && op_q == OpPulse);
    assign bus_drive   = (op_q == OpWrite) && !abort &&
                         (phase_q inside {PhSetup, PhStrobe, PhHold});

endmodule

// File: rtl/pic_host_ctrl.sv
// Host-side sequencer for an 8259A: init byte writes, two-pulse interrupt
// acknowledge with vector handoff, and specific/automatic EOI handling.
module pic_host_ctrl
    import pic_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       init_start,
    input  logic [7:0] cfg_icw1,
    input  logic [7:0] cfg_icw2,
    input  logic [7:0] cfg_icw4,
    input  logic [7:0] cfg_ocw1,
    input  logic [7:0] cfg_ocw3,
    input  logic       eoi_req,
    input  logic [2:0] eoi_level,
    output logic       eoi_ack,
    output logic       vector_valid,
    output logic [7:0] vector,
    input  logic       vector_ready,
    output logic       init_done,
    output logic       busy,
    input  logic       INT,
    output logic       INTA,
    output logic       chip_select,
    output logic       write_enable,
    output logic       read_enable,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    pic_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic [2:0] pend_level_q, pend_level_d;
    logic [2:0] wr_level_q, wr_level_d;
    logic [7:0] vector_q, vector_d;
    logic       init_done_q, init_done_d;
    logic       eoi_ack_q, eoi_ack_d;

    bus_op_e    bus_op;
    logic       bus_start, bus_idle, bus_done, bus_last, bus_drive;
    logic [7:0] wr_byte;
    logic       wr_a0;

    pic_bus_cycle #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES)
    ) u_bus (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (bus_start),
        .abort       (init_start),
        .op          (bus_op),
        .idle        (bus_idle),
        .done        (bus_done),
        .last_strobe (bus_last),
        .bus_drive   (bus_drive),
        .we_n        (write_enable),
        .inta_n      (INTA)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            pend_level_q <= 3'd0;
            wr_level_q   <= 3'd0;
            vector_q     <= 8'h00;
            init_done_q  <= 1'b0;
            eoi_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pend_level_q <= pend_level_d;
            wr_level_q   <= wr_level_d;
            vector_q     <= vector_d;
            init_done_q  <= init_done_d;
            eoi_ack_q    <= eoi_ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pend_level_d = pend_level_q;
        wr_level_d   = wr_level_q;
        vector_d     = vector_q;
        init_done_d  = init_done_q;
        eoi_ack_d    = 1'b0;
        bus_op       = OpWrite;
        wr_byte      = 8'h00;
        wr_a0        = 1'b0;
        case (state_q)
            StWIcw1: begin
                wr_byte = cfg_icw1;
                wr_a0   = A0Icw1;
                if (bus_done) state_d = StWIcw2;
            end
            StWIcw2: begin
                wr_byte = cfg_icw2;
                wr_a0   = A0Icw2;
                if (bus_done) state_d = cfg_icw1[Icw1Ic4Bit] ? StWIcw4 : StWOcw1;
            end
            StWIcw4: begin
                wr_byte = cfg_icw4;
                wr_a0   = A0Icw4;
                if (bus_done) state_d = StWOcw1;
            end
            StWOcw1: begin
                wr_byte = cfg_ocw1;
                wr_a0   = A0Ocw1;
                if (bus_done) state_d = StWOcw3;
            end
            StWOcw3: begin
                wr_byte = cfg_ocw3;
                wr_a0   = A0Ocw3;
                if (bus_done) begin
                    state_d     = StReady;
                    init_done_d = 1'b1;
                end
            end
            StReady: begin
                // EOI wins over a simultaneous interrupt request
                if (eoi_req || pending_q) begin
                    pending_d = 1'b0;
                    if (cfg_icw4[Icw4AeoiBit]) begin
                        eoi_ack_d = 1'b1;
                    end else begin
                        state_d    = StEoiWr;
                        wr_level_d = pending_q ? pend_level_q : eoi_level;
                    end
                end else if (INT) begin
                    state_d = StAck1;
                end
            end
            StAck1: begin
                bus_op = OpPulse;
                if (bus_done) state_d = StAckGap;
            end
            StAckGap: begin
                bus_op = OpGap;
                if (bus_done) state_d = StAck2;
            end
            StAck2: begin
                bus_op = OpPulse;
                if (bus_last) vector_d = data_in;
                if (bus_done) state_d = StVecHold;
            end
            StVecHold: begin
                if (vector_ready) state_d = StReady;
            end
            StEoiWr: begin
                wr_byte = specific_eoi(wr_level_q);
                wr_a0   = A0Eoi;
                if (bus_done) begin
                    state_d   = StReady;
                    eoi_ack_d = 1'b1;
                end
            end
            default: ;
        endcase
        // One-deep EOI latch; later requests are dropped until it is served
        if (state_q != StReady && eoi_req && !pending_q) begin
            pending_d    = 1'b1;
            pend_level_d = eoi_level;
        end
        if (init_start) begin
            state_d     = StWIcw1;
            init_done_d = 1'b0;
        end
    end

    assign bus_start = bus_idle && !init_start &&
                       (state_q inside {StWIcw1, StWIcw2, StWIcw4, StWOcw1, StWOcw3,
                                        StAck1, StAckGap, StAck2, StEoiWr});

    assign chip_select  = !bus_drive;
    assign read_enable  = 1'b1;
    assign A0           = bus_drive ? wr_a0 : 1'b0;
    assign data_out     = bus_drive ? wr_byte : 8'h00;
    assign data_oe      = bus_drive;
    assign vector       = vector_q;
    assign vector_valid = (state_q == StVecHold);
    assign init_done    = init_done_q;
    assign eoi_ack      = eoi_ack_q;
    assign busy         = !(state_q inside {StIdle, StReady});

endmodule

// File: tb/tb_pic_host_ctrl.sv
// Scoreboard bench for pic_host_ctrl: stimulus pushes expected bus/host events,
// a negedge monitor reconstructs events from the pins and pops/compares them.
module tb_pic_host_ctrl;

    localparam int unsigned Strobe = 2;
    localparam int unsigned Gap    = 2;

    localparam logic [1:0] EvWrite  = 2'd0;
    localparam logic [1:0] EvInta   = 2'd1;
    localparam logic [1:0] EvVector = 2'd2;
    localparam logic [1:0] EvAck    = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       a0;
        logic [7:0] data;
        logic [3:0] width;
        logic       ok;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       init_start = 1'b0;
    logic [7:0] cfg_icw1 = 8'h00, cfg_icw2 = 8'h00, cfg_icw4 = 8'h00;
    logic [7:0] cfg_ocw1 = 8'h00, cfg_ocw3 = 8'h00;
    logic       eoi_req = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       eoi_ack, vector_valid, init_done, busy;
    logic [7:0] vector;
    logic       vector_ready = 1'b0;
    logic       INT = 1'b0;
    logic       INTA, chip_select, write_enable, read_enable, A0, data_oe;
    logic [7:0] data_out;
    logic [7:0] data_in;

    int  n_cmp = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    logic [7:0] next_vec = 8'h00;

    always #5 clock = ~clock;

    pic_host_ctrl #(
        .STROBE_CYCLES (Strobe),
        .GAP_CYCLES    (Gap)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .init_start   (init_start),
        .cfg_icw1     (cfg_icw1),
        .cfg_icw2     (cfg_icw2),
        .cfg_icw4     (cfg_icw4),
        .cfg_ocw1     (cfg_ocw1),
        .cfg_ocw3     (cfg_ocw3),
        .eoi_req      (eoi_req),
        .eoi_level    (eoi_level),
        .eoi_ack      (eoi_ack),
        .vector_valid (vector_valid),
        .vector       (vector),
        .vector_ready (vector_ready),
        .init_done    (init_done),
        .busy         (busy),
        .INT          (INT),
        .INTA         (INTA),
        .chip_select  (chip_select),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .A0           (A0),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .data_in      (data_in)
    );

    function automatic ev_t mk_ev(logic [1:0] k, logic a, logic [7:0] d, logic [3:0] w);
        ev_t e;
        e.kind = k; e.a0 = a; e.data = d; e.width = w; e.ok = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic observe(input ev_t got, input string name);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event kind=%0d a0=%0d data=%02h width=%0d at %0t",
                     name, got.kind, got.a0, got.data, got.width, $time);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d a0=%0d data=%02h width=%0d ok=%0d, expected kind=%0d a0=%0d data=%02h width=%0d ok=%0d",
                         name, got.kind, got.a0, got.data, got.width, got.ok,
                         e.kind, e.a0, e.data, e.width, e.ok);
            end
        end
    endtask

    // Reference model: expected events derived from the init/EOI/acknowledge rules
    task automatic model_init(input logic [7:0] i1, i2, i4, o1, o3);
        exp_q.push_back(mk_ev(EvWrite, 1'b0, i1, 4'(Strobe)));
        exp_q.push_back(mk_ev(EvWrite, 1'b1, i2, 4'(Strobe)));
        if (i1[0]) exp_q.push_back(mk_ev(EvWrite, 1'b1, i4, 4'(Strobe)));
        exp_q.push_back(mk_ev(EvWrite, 1'b1, o1, 4'(Strobe)));
        exp_q.push_back(mk_ev(EvWrite, 1'b0, o3, 4'(Strobe)));
    endtask

    task automatic model_eoi(input logic [2:0] level, input bit aeoi);
        if (!aeoi) exp_q.push_back(mk_ev(EvWrite, 1'b0, 8'h60 + 8'(level), 4'(Strobe)));
        exp_q.push_back(mk_ev(EvAck, 1'b0, 8'h00, 4'd0));
    endtask

    task automatic model_ack(input logic [7:0] v);
        exp_q.push_back(mk_ev(EvInta, 1'b0, 8'h00, 4'(Strobe)));
        exp_q.push_back(mk_ev(EvInta, 1'b0, 8'h00, 4'(Strobe)));
        exp_q.push_back(mk_ev(EvVector, 1'b0, v, 4'd0));
    endtask

    // Monitor: turns pin activity into events, sampled mid-cycle
    int         m_we = 0, m_inta = 0;
    logic       m_ok_w = 1'b1, m_ok_i = 1'b1, m_a0 = 1'b0;
    logic [7:0] m_d = 8'h00;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                m_we = 0; m_inta = 0; m_ok_w = 1'b1; m_ok_i = 1'b1;
            end else begin
                if (!write_enable) begin
                    m_we++;
                    m_a0 = A0;
                    m_d  = data_out;
                    if (chip_select || !data_oe || !INTA) m_ok_w = 1'b0;
                end else if (m_we > 0) begin
                    observe({EvWrite, m_a0, m_d, 4'(m_we > 15 ? 15 : m_we), m_ok_w}, "bus write");
                    m_we = 0; m_ok_w = 1'b1;
                end
                if (!INTA) begin
                    m_inta++;
                    if (data_oe || !write_enable) m_ok_i = 1'b0;
                end else if (m_inta > 0) begin
                    observe({EvInta, 1'b0, 8'h00, 4'(m_inta > 15 ? 15 : m_inta), m_ok_i},
                            "inta pulse");
                    m_inta = 0; m_ok_i = 1'b1;
                end
                if (eoi_ack) observe(mk_ev(EvAck, 1'b0, 8'h00, 4'd0), "eoi ack");
                if (vector_valid && vector_ready)
                    observe(mk_ev(EvVector, 1'b0, vector, 4'd0), "vector handoff");
            end
        end
    end

    // PIC model: junk on the first INTA pulse, the vector on the second
    int r_cnt = 0;
    logic r_prev = 1'b1;
    initial begin
        data_in = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                r_cnt = 0; r_prev = 1'b1;
            end else begin
                if (r_prev && !INTA) r_cnt++;
                r_prev = INTA;
            end
            data_in = (!INTA && r_cnt > 0 && r_cnt % 2 == 0) ? next_vec : ~next_vec;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_level(input int which, input logic level, input int budget,
                              input string name);
        logic v;
        bit   hit = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            case (which)
                0:       v = INTA;
                1:       v = vector_valid;
                default: v = init_done;
            endcase
            if (v == level) begin
                hit = 1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: no level %0d within %0d clocks", name, level, budget);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_init(input logic [7:0] i1, i2, i4, o1, o3);
        cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw4 = i4; cfg_ocw1 = o1; cfg_ocw3 = o3;
        model_init(i1, i2, i4, o1, o3);
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        check("busy after init_start", busy, 1);
        check("init_done cleared", init_done, 0);
        wait_level(2, 1'b1, 300, "init_done");
    endtask

    task automatic handshake(input logic [7:0] v);
        int hold;
        wait_level(1, 1'b1, 200, "vector_valid");
        hold = $urandom_range(1, 4);
        for (int i = 0; i < hold; i++) begin
            check("vector held", {vector_valid, vector}, {1'b1, v});
            step();
        end
        INT = 1'b0;
        vector_ready = 1'b1;
        step();
        vector_ready = 1'b0;
        check("valid cleared", vector_valid, 0);
    endtask

    task automatic do_ack(input logic [7:0] v);
        next_vec = v;
        model_ack(v);
        INT = 1'b1;
        handshake(v);
        drain("ack drain");
    endtask

    task automatic do_eoi_int(input logic [2:0] level, input logic [7:0] v);
        next_vec = v;
        model_eoi(level, 1'b0);
        model_ack(v);
        eoi_req = 1'b1; eoi_level = level; INT = 1'b1;
        step();
        eoi_req = 1'b0;
        handshake(v);
        drain("eoi+int drain");
    endtask

    initial begin
        logic [7:0] r8;
        logic [2:0] lv;
        #2;
        check("rst INTA", INTA, 1);
        check("rst cs/we/rd", {chip_select, write_enable, read_enable}, 3'b111);
        check("rst A0/data_out/oe", {A0, data_out, data_oe}, 10'd0);
        check("rst vector/valid", {vector, vector_valid}, 9'd0);
        check("rst ack/done/busy", {eoi_ack, init_done, busy}, 3'd0);
        step();
        reset_n = 1'b1;

        // INT before init is ignored
        INT = 1'b1;
        repeat (10) step();
        check("pre-init idle", {busy, INTA, chip_select}, 3'b011);
        INT = 1'b0;

        do_init(8'h1F, 8'hA8, 8'h01, 8'h00, 8'h08);
        drain("init five writes");
        check("init_done held", init_done, 1);

        do_ack(8'hA9);
        for (int i = 0; i < 4; i++) do_ack(8'($urandom));

        do_eoi_int(3'b100, 8'($urandom));
        for (int i = 0; i < 3; i++) do_eoi_int(3'($urandom), 8'($urandom));

        for (int i = 0; i < 2; i++) begin
            lv = 3'($urandom);
            model_eoi(lv, 1'b0);
            eoi_req = 1'b1; eoi_level = lv;
            step();
            eoi_req = 1'b0;
            drain("plain eoi");
        end

        // EOI during acknowledge is latched; a second one is dropped
        r8 = 8'($urandom);
        lv = 3'($urandom);
        next_vec = r8;
        model_ack(r8);
        model_eoi(lv, 1'b0);
        INT = 1'b1;
        wait_level(0, 1'b0, 50, "inta low");
        eoi_req = 1'b1; eoi_level = lv;
        step();
        eoi_req = 1'b0;
        step(); step();
        eoi_req = 1'b1; eoi_level = ~lv;
        step();
        eoi_req = 1'b0;
        handshake(r8);
        drain("pending eoi");

        do_init({7'($urandom), 1'b0}, 8'($urandom), 8'($urandom) & 8'hFD,
                8'($urandom), 8'($urandom));
        drain("init four writes");
        do_ack(8'($urandom));

        // Automatic EOI: ack next clock, no bus write
        do_init(8'h1F, 8'($urandom), 8'h03, 8'($urandom), 8'($urandom));
        drain("init aeoi");
        model_eoi(3'($urandom), 1'b1);
        eoi_req = 1'b1; eoi_level = 3'($urandom);
        step();
        eoi_req = 1'b0;
        check("aeoi ack next clock", {eoi_ack, write_enable}, 2'b11);
        step();
        check("aeoi ack one clock", eoi_ack, 0);
        drain("aeoi drain");

        // Reset during the second INTA pulse
        next_vec = 8'($urandom);
        exp_q.push_back(mk_ev(EvInta, 1'b0, 8'h00, 4'(Strobe)));
        INT = 1'b1;
        wait_level(0, 1'b0, 50, "first inta");
        wait_level(0, 1'b1, 50, "inta gap");
        wait_level(0, 1'b0, 50, "second inta");
        reset_n = 1'b0;
        #1;
        check("reset INTA high", INTA, 1);
        check("reset state", {vector_valid, busy, init_done, write_enable, chip_select}, 5'b00011);
        step(); step();
        reset_n = 1'b1;
        repeat (20) step();
        check("post reset quiet", {busy, INTA, vector_valid}, 3'b010);
        check("post reset events", exp_q.size(), 0);
        exp_q.delete();

        // EOI requested before init is served once READY is reached
        lv = 3'($urandom);
        eoi_req = 1'b1; eoi_level = lv;
        step();
        eoi_req = 1'b0;
        INT = 1'b0;
        do_init({7'($urandom), 1'b1}, 8'($urandom), 8'($urandom) & 8'hFD,
                8'($urandom), 8'($urandom));
        model_eoi(lv, 1'b0);
        drain("pre-init eoi");
        do_ack(8'($urandom));
        check("read_enable idle", read_enable, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
